// File: rtl/hot_page_report_queue.sv
// Hot-page report queue: captures strobed (addr, cnt) reports tagged with the epoch
// number, buffers them first-word-fall-through, and drains over valid/ready.
module hot_page_report_queue #(
    parameter int ADDR_SIZE = 21,
    parameter int CNT_SIZE  = 12,
    parameter int EPOCH_W   = 8,
    parameter int DEPTH     = 64,
    parameter int WM_LEVEL  = 48,
    parameter int DROP_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [ADDR_SIZE-1:0]       in_addr,
    input  logic [CNT_SIZE-1:0]        in_cnt,
    input  logic                       epoch,
    input  logic                       flush,
    input  logic                       drop_clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_SIZE-1:0]       out_addr,
    output logic [CNT_SIZE-1:0]        out_cnt,
    output logic [EPOCH_W-1:0]         out_epoch,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic                       almost_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = ADDR_SIZE + CNT_SIZE + EPOCH_W;

    typedef logic [ENT_W-1:0] entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [LVL_W-1:0]   level_reg, level_next;
    logic [EPOCH_W-1:0] epoch_num_reg, epoch_num_next;
    logic [DROP_W-1:0]  drop_cnt_reg, drop_cnt_next;
    logic               almost_full_reg;
    logic               full, pop_raw, push_ok, overflow, wr_en;
    entry_t             head;

    // A pop frees a slot at the same edge, so a full queue still accepts a push then.
    always_comb begin
        full     = (level_reg == LVL_W'(DEPTH));
        pop_raw  = (level_reg != '0) && out_ready;
        push_ok  = in_valid && (!full || pop_raw);
        overflow = in_valid && full && !pop_raw && !flush;
        wr_en    = push_ok && !flush && rst_n;
    end

    always_comb begin
        rd_ptr_next    = rd_ptr_reg;
        wr_ptr_next    = wr_ptr_reg;
        level_next     = level_reg;
        epoch_num_next = epoch ? epoch_num_reg + 1'b1 : epoch_num_reg;
        drop_cnt_next  = drop_cnt_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (pop_raw) rd_ptr_next = rd_ptr_reg + 1'b1;
            if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
            level_next = level_reg + LVL_W'(push_ok) - LVL_W'(pop_raw);
        end
        if (drop_clr)
            drop_cnt_next = DROP_W'(overflow);
        else if (overflow && (drop_cnt_reg != '1))
            drop_cnt_next = drop_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            level_reg       <= '0;
            epoch_num_reg   <= '0;
            drop_cnt_reg    <= '0;
            almost_full_reg <= 1'b0;
        end else begin
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            level_reg       <= level_next;
            epoch_num_reg   <= epoch_num_next;
            drop_cnt_reg    <= drop_cnt_next;
            almost_full_reg <= (level_next >= LVL_W'(WM_LEVEL));
        end
    end

    // Tag uses the pre-increment epoch: a report coincident with the pulse closes the old epoch.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= {in_addr, in_cnt, epoch_num_reg};
    end

    always_comb begin
        head      = mem[rd_ptr_reg];
        out_valid = (level_reg != '0);
        out_addr  = '0;
        out_cnt   = '0;
        out_epoch = '0;
        if (out_valid) begin
            out_addr  = head[ENT_W-1 -: ADDR_SIZE];
            out_cnt   = head[EPOCH_W +: CNT_SIZE];
            out_epoch = head[EPOCH_W-1:0];
        end
    end

    assign level       = level_reg;
    assign drop_cnt    = drop_cnt_reg;
    assign almost_full = almost_full_reg;

endmodule

// File: tb/tb_hot_page_report_queue.sv
// Bench for hot_page_report_queue: directed vector table plus queue-based scoreboard
// that models accept/drop/flush/epoch behaviour cycle by cycle.
module tb_hot_page_report_queue;
    localparam int ADDR_SIZE = 21;
    localparam int CNT_SIZE  = 12;
    localparam int EPOCH_W   = 8;
    localparam int DEPTH     = 64;
    localparam int WM_LEVEL  = 48;
    localparam int DROP_W    = 16;
    localparam int LVL_W     = $clog2(DEPTH) + 1;
    localparam int ENT_W     = ADDR_SIZE + CNT_SIZE + EPOCH_W;
    localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;

    typedef logic [ENT_W-1:0] ent_t;

    typedef struct {
        bit                   iv;
        logic [ADDR_SIZE-1:0] a;
        logic [CNT_SIZE-1:0]  c;
        bit                   ep;
        bit                   rdy;
        bit                   e_valid;
        logic [ADDR_SIZE-1:0] e_addr;
        logic [CNT_SIZE-1:0]  e_cnt;
        logic [EPOCH_W-1:0]   e_epoch;
        int                   e_level;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic [ADDR_SIZE-1:0] in_addr = '0;
    logic [CNT_SIZE-1:0]  in_cnt = '0;
    logic                 epoch = 1'b0;
    logic                 flush = 1'b0;
    logic                 drop_clr = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 out_valid;
    logic [ADDR_SIZE-1:0] out_addr;
    logic [CNT_SIZE-1:0]  out_cnt;
    logic [EPOCH_W-1:0]   out_epoch;
    logic [LVL_W-1:0]     level;
    logic [DROP_W-1:0]    drop_cnt;
    logic                 almost_full;

    hot_page_report_queue #(
        .ADDR_SIZE(ADDR_SIZE), .CNT_SIZE(CNT_SIZE), .EPOCH_W(EPOCH_W),
        .DEPTH(DEPTH), .WM_LEVEL(WM_LEVEL), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr),
        .in_cnt(in_cnt), .epoch(epoch), .flush(flush), .drop_clr(drop_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_cnt(out_cnt), .out_epoch(out_epoch), .level(level),
        .drop_cnt(drop_cnt), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    ent_t               sb[$];
    logic [EPOCH_W-1:0] m_epoch = '0;
    int unsigned        m_drop = 0;
    int                 n_vec = 0;
    int                 n_fail = 0;
    vec_t               vt[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0)
            chk("head", 64'({out_addr, out_cnt, out_epoch}), 64'(sb[0]));
        else
            chk("head_zero", 64'({out_addr, out_cnt, out_epoch}), 64'(0));
        chk("level", 64'(level), 64'(sb.size()));
        chk("almost_full", 64'(almost_full), 64'(sb.size() >= WM_LEVEL));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    endtask

    // Drive one cycle, advance the model across the edge, then compare #1 after it.
    task automatic step(input bit iv, input logic [ADDR_SIZE-1:0] a, input logic [CNT_SIZE-1:0] c,
                        input bit ep, input bit fl, input bit dc, input bit rdy);
        bit   full, pop, ovf;
        ent_t popped;
        in_valid = iv; in_addr = a; in_cnt = c;
        epoch = ep; flush = fl; drop_clr = dc; out_ready = rdy;
        full = (sb.size() == DEPTH);
        pop  = (sb.size() != 0) && rdy;
        ovf  = 1'b0;
        if (fl) begin
            sb.delete();
        end else begin
            if (pop) begin
                popped = sb.pop_front();
                chk("pop_data", 64'({out_addr, out_cnt, out_epoch}), 64'(popped));
                $display("pop addr=%h cnt=%0d epoch=%0d", out_addr, out_cnt, out_epoch);
            end
            if (iv) begin
                if (!full || pop) sb.push_back({a, c, m_epoch});
                else ovf = 1'b1;
            end
        end
        if (dc) m_drop = ovf ? 1 : 0;
        else if (ovf && m_drop != DROP_MAX) m_drop++;
        if (ep) m_epoch = m_epoch + 1'b1;
        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b1; in_addr = '1; in_cnt = '1;
        epoch = 1'b1; flush = 1'b0; drop_clr = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        m_epoch = '0;
        m_drop = 0;
        $display("reset applied");
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        // Directed table: single report held stable, then epoch tagging across a boundary.
        vt[0] = '{1'b1, 21'h1ABCD, 12'd20, 1'b0, 1'b0, 1'b1, 21'h1ABCD, 12'd20, 8'd0, 1};
        for (int i = 1; i <= 5; i++)
            vt[i] = '{1'b0, 21'h0, 12'd0, 1'b0, 1'b0, 1'b1, 21'h1ABCD, 12'd20, 8'd0, 1};
        vt[6] = '{1'b1, 21'h00BEE, 12'd5, 1'b1, 1'b0, 1'b1, 21'h1ABCD, 12'd20, 8'd0, 2};
        vt[7] = '{1'b1, 21'h1F00F, 12'd7, 1'b0, 1'b1, 1'b1, 21'h00BEE, 12'd5,  8'd0, 2};
        vt[8] = '{1'b0, 21'h0,     12'd0, 1'b0, 1'b1, 1'b1, 21'h1F00F, 12'd7,  8'd1, 1};
        vt[9] = '{1'b0, 21'h0,     12'd0, 1'b0, 1'b1, 1'b0, 21'h0,     12'd0,  8'd0, 0};

        do_reset();

        for (int i = 0; i < 10; i++) begin
            step(vt[i].iv, vt[i].a, vt[i].c, vt[i].ep, 1'b0, 1'b0, vt[i].rdy);
            chk("tbl_valid", 64'(out_valid), 64'(vt[i].e_valid));
            chk("tbl_addr",  64'(out_addr),  64'(vt[i].e_addr));
            chk("tbl_cnt",   64'(out_cnt),   64'(vt[i].e_cnt));
            chk("tbl_epoch", 64'(out_epoch), 64'(vt[i].e_epoch));
            chk("tbl_level", 64'(level),     64'(vt[i].e_level));
        end

        // Fill to capacity, overflow, overflow-with-pop, drop_clr interactions.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, ADDR_SIZE'(32'h100 + i), CNT_SIZE'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == WM_LEVEL - 2) chk("af_below_wm", 64'(almost_full), 64'(0));
            if (i == WM_LEVEL - 1) chk("af_at_wm", 64'(almost_full), 64'(1));
        end
        chk("full_level", 64'(level), 64'(DEPTH));
        step(1'b1, 21'h0DEAD, 12'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_drop", 64'(drop_cnt), 64'(1));
        chk("ovf_level", 64'(level), 64'(DEPTH));
        step(1'b1, 21'h0BEEF, 12'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("full_pop_push_level", 64'(level), 64'(DEPTH));
        chk("full_pop_push_drop", 64'(drop_cnt), 64'(1));
        step(1'b1, 21'h0CAFE, 12'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 21'h0CAFE, 12'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_with_ovf", 64'(drop_cnt), 64'(1));
        step(1'b0, 21'h0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_only", 64'(drop_cnt), 64'(0));
        step(1'b0, 21'h0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // 255 more epoch pulses after the one in the table -> tag wraps to 0.
        for (int i = 0; i < 255; i++)
            step(1'b0, 21'h0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 21'h12345, 12'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("epoch_wrap_tag", 64'(out_epoch), 64'(0));
        step(1'b0, 21'h0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Push 10, pop 3, flush with a coincident push and epoch.
        for (int i = 0; i < 10; i++)
            step(1'b1, ADDR_SIZE'(32'h2000 + i), CNT_SIZE'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 21'h0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pre_flush_level", 64'(level), 64'(7));
        step(1'b1, 21'h0F1F1, 12'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("flush_valid", 64'(out_valid), 64'(0));
        chk("flush_level", 64'(level), 64'(0));
        chk("flush_drop", 64'(drop_cnt), 64'(0));
        step(1'b1, 21'h1D00D, 12'd77, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_flush_addr", 64'(out_addr), 64'(21'h1D00D));
        chk("post_flush_cnt", 64'(out_cnt), 64'(77));
        chk("post_flush_epoch", 64'(out_epoch), 64'(1));

        // Random traffic biased toward filling so the full/drop path is exercised.
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(99) < 70, ADDR_SIZE'($urandom), CNT_SIZE'($urandom),
                 $urandom_range(49) == 0, $urandom_range(999) == 0,
                 $urandom_range(399) == 0, $urandom_range(99) < 50);
        end

        // Reset with entries queued: everything returns to reset values.
        for (int i = 0; i < 5; i++)
            step(1'b1, ADDR_SIZE'(32'h3000 + i), CNT_SIZE'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 21'h15555, 12'd33, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_reset_addr", 64'(out_addr), 64'(21'h15555));
        chk("post_reset_level", 64'(level), 64'(1));
        step(1'b0, 21'h0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
